// File: rtl/du_dump_receiver.sv
// Debug-dump receiver: rebuilds PC, cycle count, register file and dirty-memory
// records from the byte stream the debug unit sends after a halt or step.
module du_dump_receiver #(
   parameter int NB_DATA    = 32,
   parameter int NB_REG     = 5,
   parameter int N_BITS     = 8,
   parameter int N_REGS     = 32,
   parameter int N_BYTES    = 4,
   parameter int N_TIMEOUT  = 100000,
   parameter int NB_TIMEOUT = 20
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [N_BITS-1:0]  i_rx_data,
   input  logic               i_arm,
   output logic [N_BITS-1:0]  o_pc,
   output logic [N_BITS-1:0]  o_cycles,
   output logic               o_reg_we,
   output logic [NB_REG-1:0]  o_reg_addr,
   output logic [NB_DATA-1:0] o_reg_data,
   output logic               o_mem_we,
   output logic [N_BITS-1:0]  o_mem_addr,
   output logic [NB_DATA-1:0] o_mem_data,
   output logic [N_BITS-1:0]  o_mem_count,
   output logic               o_busy,
   output logic               o_frame_done,
   output logic               o_error,
   output logic [2:0]         o_state
);

   // state    | meaning
   // IDLE     | waiting for arm; stray bytes flag an error
   // PC       | expecting program-counter byte
   // CYC      | expecting cycle-count byte
   // REG      | assembling register words, index 0..N_REGS-1
   // MEM_ADDR | expecting a record address, or idle timeout ends the dump
   // MEM_DATA | assembling a record data word
   // DONE     | one-cycle frame-done pulse
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] PC       = 3'd1;
   localparam logic [2:0] CYC      = 3'd2;
   localparam logic [2:0] REG      = 3'd3;
   localparam logic [2:0] MEM_ADDR = 3'd4;
   localparam logic [2:0] MEM_DATA = 3'd5;
   localparam logic [2:0] DONE     = 3'd6;

   localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [NB_BCNT-1:0]    BYTE_LAST = NB_BCNT'(N_BYTES - 1);
   localparam logic [NB_REG-1:0]     REG_LAST  = NB_REG'(N_REGS - 1);
   localparam logic [NB_TIMEOUT-1:0] TMO_LAST  = NB_TIMEOUT'(N_TIMEOUT - 1);

   logic [2:0]              state;
   logic [2:0]              state_nx;
   logic [NB_BCNT-1:0]      byte_cnt;
   logic [NB_REG-1:0]       reg_idx;
   logic [NB_TIMEOUT-1:0]   tmo_cnt;
   logic [NB_DATA-N_BITS-1:0] acc;
   logic                    strobe;
   logic                    word_last;
   logic                    timed;
   logic                    tmo_hit;

   always_comb begin
      strobe    = i_rx_done & ~i_arm;
      word_last = strobe && (byte_cnt == BYTE_LAST);
      timed     = (state == PC) || (state == CYC) || (state == REG) ||
                  (state == MEM_ADDR) || (state == MEM_DATA);
      tmo_hit   = timed && !i_rx_done && (tmo_cnt == TMO_LAST);
      state_nx  = state;
      if (i_arm) begin
         state_nx = PC;
      end else begin
         case (state)
            IDLE:     state_nx = IDLE;
            PC:       if (strobe) state_nx = CYC;
                      else if (tmo_hit) state_nx = DONE;
            CYC:      if (strobe) state_nx = REG;
                      else if (tmo_hit) state_nx = DONE;
            REG:      if (word_last && (reg_idx == REG_LAST)) state_nx = MEM_ADDR;
                      else if (tmo_hit) state_nx = DONE;
            MEM_ADDR: if (strobe) state_nx = MEM_DATA;
                      else if (tmo_hit) state_nx = DONE;
            MEM_DATA: if (word_last) state_nx = MEM_ADDR;
                      else if (tmo_hit) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state        <= IDLE;
         byte_cnt     <= '0;
         reg_idx      <= '0;
         tmo_cnt      <= '0;
         acc          <= '0;
         o_pc         <= '0;
         o_cycles     <= '0;
         o_reg_we     <= 1'b0;
         o_reg_addr   <= '0;
         o_reg_data   <= '0;
         o_mem_we     <= 1'b0;
         o_mem_addr   <= '0;
         o_mem_data   <= '0;
         o_mem_count  <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_error      <= 1'b0;
      end else begin
         state        <= state_nx;
         o_busy       <= (state_nx != IDLE);
         o_frame_done <= (state_nx == DONE);
         o_reg_we     <= 1'b0;
         o_mem_we     <= 1'b0;
         if (i_arm) begin
            byte_cnt    <= '0;
            reg_idx     <= '0;
            tmo_cnt     <= '0;
            o_mem_count <= '0;
            o_error     <= 1'b0;
         end else begin
            // Idle-gap counter: cleared by any byte, only runs while a dump is open
            if (!timed || i_rx_done || tmo_hit)
               tmo_cnt <= '0;
            else if (tmo_cnt != '1)
               tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
               IDLE: if (i_rx_done) o_error <= 1'b1;
               PC:   if (strobe) o_pc <= i_rx_data;
               CYC:  if (strobe) o_cycles <= i_rx_data;
               REG: if (strobe) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  if (word_last) begin
                     byte_cnt   <= '0;
                     o_reg_data <= {i_rx_data, acc};
                     o_reg_addr <= reg_idx;
                     o_reg_we   <= 1'b1;
                     reg_idx    <= reg_idx + 1'b1;
                  end else begin
                     acc <= {i_rx_data, acc[NB_DATA-N_BITS-1:N_BITS]};
                  end
               end
               MEM_ADDR: if (strobe) begin
                  o_mem_addr <= i_rx_data;
                  byte_cnt   <= '0;
               end
               MEM_DATA: if (strobe) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  if (word_last) begin
                     byte_cnt   <= '0;
                     o_mem_data <= {i_rx_data, acc};
                     o_mem_we   <= 1'b1;
                     if (o_mem_count != '1) o_mem_count <= o_mem_count + 1'b1;
                  end else begin
                     acc <= {i_rx_data, acc[NB_DATA-N_BITS-1:N_BITS]};
                  end
               end
               default: ;
            endcase

            // A timeout drops any half-built word; only MEM_ADDR ends cleanly
            if (tmo_hit) begin
               byte_cnt <= '0;
               if (state != MEM_ADDR) o_error <= 1'b1;
            end
         end
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_du_dump_receiver.sv
// Scoreboard bench for du_dump_receiver: expected register/memory writes are
// queued as bytes are driven and checked as the write strobes appear.
module tb_du_dump_receiver;

   localparam int TMO = 200;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_rx_done = 1'b0;
   logic [7:0]  i_rx_data = '0;
   logic        i_arm = 1'b0;
   logic [7:0]  o_pc, o_cycles, o_mem_addr, o_mem_count;
   logic        o_reg_we, o_mem_we, o_busy, o_frame_done, o_error;
   logic [4:0]  o_reg_addr;
   logic [31:0] o_reg_data, o_mem_data;
   logic [2:0]  o_state;

   int n_cmp = 0;
   int n_err = 0;
   int frame_cnt = 0;

   logic [4:0]  reg_addr_q[$];
   logic [31:0] reg_data_q[$];
   logic [7:0]  mem_addr_q[$];
   logic [31:0] mem_data_q[$];

   du_dump_receiver #(.N_TIMEOUT(TMO)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_rx_done(i_rx_done),
      .i_rx_data(i_rx_data), .i_arm(i_arm), .o_pc(o_pc), .o_cycles(o_cycles),
      .o_reg_we(o_reg_we), .o_reg_addr(o_reg_addr), .o_reg_data(o_reg_data),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
      .o_mem_count(o_mem_count), .o_busy(o_busy), .o_frame_done(o_frame_done),
      .o_error(o_error), .o_state(o_state)
   );

   always #5 i_clock = ~i_clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every write strobe must match the oldest queued expectation
   always @(negedge i_clock) begin
      if (!i_reset) begin
         if (o_reg_we) begin
            n_cmp++;
            if (reg_addr_q.size() == 0) begin
               n_err++;
               $display("FAIL reg_we_unexpected: got addr %0d data %h, required no write", o_reg_addr, o_reg_data);
            end else begin
               logic [4:0]  ea;
               logic [31:0] ed;
               ea = reg_addr_q.pop_front();
               ed = reg_data_q.pop_front();
               if (o_reg_addr !== ea || o_reg_data !== ed) begin
                  n_err++;
                  $display("FAIL reg_write: got addr %0d data %h, required addr %0d data %h", o_reg_addr, o_reg_data, ea, ed);
               end
            end
         end
         if (o_mem_we) begin
            n_cmp++;
            if (mem_addr_q.size() == 0) begin
               n_err++;
               $display("FAIL mem_we_unexpected: got addr %h data %h, required no write", o_mem_addr, o_mem_data);
            end else begin
               logic [7:0]  ea;
               logic [31:0] ed;
               ea = mem_addr_q.pop_front();
               ed = mem_data_q.pop_front();
               if (o_mem_addr !== ea || o_mem_data !== ed) begin
                  n_err++;
                  $display("FAIL mem_write: got addr %h data %h, required addr %h data %h", o_mem_addr, o_mem_data, ea, ed);
               end
            end
         end
         if (o_frame_done) frame_cnt++;
      end
   end

   // All drivers enter and leave 1 time unit after a rising edge
   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_done = 1'b1;
      i_rx_data = b;
      @(posedge i_clock); #1;
      i_rx_done = 1'b0;
      repeat (gap) begin @(posedge i_clock); #1; end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic arm();
      i_arm = 1'b1;
      @(posedge i_clock); #1;
      i_arm = 1'b0;
   endtask

   task automatic send_regs(input int first, input int last);
      for (int r = first; r <= last; r++) begin
         reg_addr_q.push_back(5'(r));
         reg_data_q.push_back(32'h0000_0100 + 32'(r));
         send_word(32'h0000_0100 + 32'(r), 0);
      end
   endtask

   task automatic send_mem(input logic [7:0] a, input logic [31:0] d, input int gap);
      mem_addr_q.push_back(a);
      mem_data_q.push_back(d);
      send_byte(a, gap);
      send_word(d, gap);
   endtask

   task automatic wait_frame(output int cycles);
      cycles = 0;
      for (int i = 0; i < TMO + 50; i++) begin
         @(negedge i_clock);
         cycles++;
         if (o_frame_done) break;
      end
      if (!o_frame_done) begin
         n_cmp++; n_err++;
         $display("FAIL frame_done_timeout: no frame_done within %0d cycles", TMO + 50);
      end
      @(posedge i_clock); #1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      #1;
      n_cmp++;
      if ({o_pc, o_cycles, o_reg_addr, o_reg_data, o_mem_addr, o_mem_data, o_mem_count} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got pc %h cyc %h cnt %h, required all zero", o_pc, o_cycles, o_mem_count);
      end
      n_cmp++;
      if ({o_reg_we, o_mem_we, o_busy, o_frame_done, o_error, o_state} !== '0) begin
         n_err++;
         $display("FAIL reset_flags: got we %b/%b busy %b done %b err %b state %0d, required zero",
                  o_reg_we, o_mem_we, o_busy, o_frame_done, o_error, o_state);
      end
      repeat (3) @(posedge i_clock);
      #1 i_reset = 1'b0;
      @(posedge i_clock); #1;
   endtask

   task automatic test_full_dump();
      int f0, cyc;
      f0 = frame_cnt;
      arm();
      n_cmp++;
      if (o_busy !== 1'b1 || o_state !== 3'd1) begin
         n_err++;
         $display("FAIL arm_state: got busy %b state %0d, required busy 1 state 1", o_busy, o_state);
      end
      send_byte(8'h05, 0);
      send_byte(8'h0A, 0);
      send_regs(0, 31);
      wait_frame(cyc);
      n_cmp++;
      if (cyc !== TMO + 1) begin
         n_err++;
         $display("FAIL end_latency: got %0d cycles, required %0d", cyc, TMO + 1);
      end
      n_cmp++;
      if (o_pc !== 8'h05 || o_cycles !== 8'h0A) begin
         n_err++;
         $display("FAIL full_pc_cyc: got pc %h cyc %h, required 05 0a", o_pc, o_cycles);
      end
      n_cmp++;
      if (o_mem_count !== 8'd0 || o_error !== 1'b0) begin
         n_err++;
         $display("FAIL full_count_err: got count %0d err %b, required 0 0", o_mem_count, o_error);
      end
      n_cmp++;
      if (reg_addr_q.size() != 0 || frame_cnt - f0 != 1) begin
         n_err++;
         $display("FAIL full_writes: got %0d pending regs, %0d frames, required 0 and 1", reg_addr_q.size(), frame_cnt - f0);
      end
      n_cmp++;
      if (o_state !== 3'd0 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL full_idle: got state %0d busy %b, required 0 0", o_state, o_busy);
      end
   endtask

   task automatic test_mem_records();
      int f0, cyc;
      f0 = frame_cnt;
      arm();
      send_byte(8'h05, 0);
      send_byte(8'h0A, 0);
      send_regs(0, 31);
      repeat (20) begin @(posedge i_clock); #1; end
      send_mem(8'h03, 32'hDEAD_BEEF, 3);
      send_mem(8'h7F, 32'h0000_0001, 150);
      wait_frame(cyc);
      n_cmp++;
      if (o_mem_count !== 8'd2 || o_error !== 1'b0) begin
         n_err++;
         $display("FAIL mem_count: got count %0d err %b, required 2 0", o_mem_count, o_error);
      end
      n_cmp++;
      if (mem_addr_q.size() != 0 || reg_addr_q.size() != 0 || frame_cnt - f0 != 1) begin
         n_err++;
         $display("FAIL mem_writes: got %0d pending mem, %0d pending regs, %0d frames, required 0 0 1",
                  mem_addr_q.size(), reg_addr_q.size(), frame_cnt - f0);
      end
   endtask

   task automatic test_partial();
      int f0, cyc;
      f0 = frame_cnt;
      arm();
      send_byte(8'h05, 0);
      send_byte(8'h0A, 0);
      send_regs(0, 6);
      send_byte(8'h07, 0);
      send_byte(8'h01, 0);
      wait_frame(cyc);
      repeat (2) begin @(posedge i_clock); #1; end
      n_cmp++;
      if (o_error !== 1'b1 || o_state !== 3'd0) begin
         n_err++;
         $display("FAIL partial_err: got err %b state %0d, required 1 0", o_error, o_state);
      end
      n_cmp++;
      if (reg_addr_q.size() != 0 || o_reg_addr !== 5'd6 || frame_cnt - f0 != 1) begin
         n_err++;
         $display("FAIL partial_writes: got %0d pending, last addr %0d, %0d frames, required 0 6 1",
                  reg_addr_q.size(), o_reg_addr, frame_cnt - f0);
      end
   endtask

   task automatic test_idle_byte();
      i_reset = 1'b1;
      @(posedge i_clock); #1;
      i_reset = 1'b0;
      @(posedge i_clock); #1;
      send_byte(8'h55, 2);
      n_cmp++;
      if (o_error !== 1'b1 || o_state !== 3'd0 || o_pc !== 8'h00) begin
         n_err++;
         $display("FAIL idle_byte: got err %b state %0d pc %h, required 1 0 00", o_error, o_state, o_pc);
      end
      arm();
      n_cmp++;
      if (o_error !== 1'b0) begin
         n_err++;
         $display("FAIL arm_clears_err: got err %b, required 0", o_error);
      end
   endtask

   task automatic test_arm_collision();
      int cyc;
      arm();
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_regs(0, 2);
      send_byte(8'h03, 0);
      i_arm = 1'b1;
      i_rx_done = 1'b1;
      i_rx_data = 8'hAA;
      @(posedge i_clock); #1;
      i_arm = 1'b0;
      i_rx_done = 1'b0;
      n_cmp++;
      if (o_state !== 3'd1 || o_pc !== 8'h11) begin
         n_err++;
         $display("FAIL collision_state: got state %0d pc %h, required 1 11", o_state, o_pc);
      end
      send_byte(8'h21, 0);
      send_byte(8'h42, 0);
      send_regs(0, 31);
      wait_frame(cyc);
      n_cmp++;
      if (o_pc !== 8'h21 || o_cycles !== 8'h42 || o_error !== 1'b0 || reg_addr_q.size() != 0) begin
         n_err++;
         $display("FAIL collision_dump: got pc %h cyc %h err %b pending %0d, required 21 42 0 0",
                  o_pc, o_cycles, o_error, reg_addr_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int f0;
      arm();
      send_byte(8'h05, 0);
      send_byte(8'h0A, 0);
      send_regs(0, 31);
      send_byte(8'h10, 1);
      send_byte(8'h44, 1);
      send_byte(8'h33, 1);
      f0 = frame_cnt;
      n_cmp++;
      if (o_state !== 3'd5) begin
         n_err++;
         $display("FAIL pre_reset_state: got %0d, required 5", o_state);
      end
      i_reset = 1'b1;
      #2;
      n_cmp++;
      if ({o_pc, o_cycles, o_reg_addr, o_reg_data, o_mem_addr, o_mem_data, o_mem_count,
           o_reg_we, o_mem_we, o_busy, o_frame_done, o_error, o_state} !== '0) begin
         n_err++;
         $display("FAIL mid_reset: got pc %h state %0d busy %b addr %h, required all zero", o_pc, o_state, o_busy, o_mem_addr);
      end
      repeat (3) @(posedge i_clock);
      #1 i_reset = 1'b0;
      repeat (TMO + 20) begin @(posedge i_clock); #1; end
      n_cmp++;
      if (frame_cnt != f0 || o_state !== 3'd0 || o_mem_count !== 8'd0 || mem_addr_q.size() != 0) begin
         n_err++;
         $display("FAIL post_reset: got %0d frames state %0d count %0d, required 0 0 0",
                  frame_cnt - f0, o_state, o_mem_count);
      end
   endtask

   initial begin
      @(posedge i_clock); #1;
      test_reset();
      test_full_dump();
      test_mem_records();
      test_partial();
      test_idle_byte();
      test_arm_collision();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
